// File: rtl/qdec_ctx_init_if.sv
// Signal bundle between the context-init engine and its surroundings: slice control, init ROM port
// and the write side of the context memory port.
// Protocol: start is a one-cycle request taken only while idle; init_value is valid exactly one
// cycle after init_rd; every cycle with ctx_we=1 is one committed write, with no stalls.
interface qdec_ctx_init_if #(
   parameter int CTX_AW  = 10,
   parameter int INIT_AW = 11
);
   logic               start;
   logic [6:0]         slice_qp;
   logic [1:0]         init_type;
   logic               busy;
   logic               done;
   logic               init_rd;
   logic [INIT_AW-1:0] init_addr;
   logic [7:0]         init_value;
   logic [CTX_AW-1:0]  ctx_addr;
   logic [7:0]         ctx_wdata;
   logic               ctx_we;
   logic               ctx_en;

   modport slave (
      input  start, slice_qp, init_type, init_value,
      output busy, done, init_rd, init_addr, ctx_addr, ctx_wdata, ctx_we, ctx_en
   );

   modport master (
      output start, slice_qp, init_type, init_value,
      input  busy, done, init_rd, init_addr, ctx_addr, ctx_wdata, ctx_we, ctx_en
   );
endinterface

// File: rtl/qdec_ctx_init.sv
// CABAC context initialisation: walks every context, reads its initValue from the init ROM,
// derives {pStateIdx, valMps} from SliceQpY and writes it into context memory, one per cycle.
module qdec_ctx_init #(
   parameter int NUM_CTX = 512,
   parameter int CTX_AW  = 10,
   parameter int INIT_AW = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   qdec_ctx_init_if.slave        bus,
   output logic [1:0]            state_o
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [CTX_AW-1:0] LAST = CTX_AW'(NUM_CTX - 1);

   state_e             state_q, state_d;
   logic [CTX_AW-1:0]  cnt_q, cnt_d;
   logic               rd_q, rd_d;
   logic [INIT_AW-1:0] rd_addr_q, rd_addr_d;
   logic [5:0]         qc_q, qc_d;
   logic               v1_q, v1_d;
   logic [CTX_AW-1:0]  k1_q, k1_d;
   logic               we_q, we_d;
   logic [CTX_AW-1:0]  waddr_q, waddr_d;
   logic [7:0]         wdata_q, wdata_d;

   logic [5:0]         qc_in;
   logic [INIT_AW-1:0] base_in;

   always_comb begin
      qc_in = bus.slice_qp[5:0];
      if (bus.slice_qp[6]) begin
         qc_in = 6'd0;
      end else if (bus.slice_qp[5:0] > 6'd51) begin
         qc_in = 6'd51;
      end
   end

   always_comb begin
      base_in = '0;
      unique case (bus.init_type)
         2'd0:    base_in = '0;
         2'd1:    base_in = INIT_AW'(NUM_CTX);
         default: base_in = INIT_AW'(2 * NUM_CTX);
      endcase
   end

   // State derivation for the ROM word arriving this cycle; all terms fit in 14-bit signed.
   logic [3:0]         slope, off;
   logic signed [13:0] m_s, n_s, prod_s, sum_s;
   logic [6:0]         pre;
   logic               val_mps;
   logic [5:0]         pidx;
   logic [7:0]         ctx_state;

   always_comb begin
      slope  = bus.init_value[7:4];
      off    = bus.init_value[3:0];
      m_s    = $signed({10'd0, slope}) * 14'sd5 - 14'sd45;
      n_s    = $signed({7'd0, off, 3'd0}) - 14'sd16;
      prod_s = m_s * $signed({8'd0, qc_q});
      sum_s  = (prod_s >>> 4) + n_s;
      if (sum_s < 14'sd1) begin
         pre = 7'd1;
      end else if (sum_s > 14'sd126) begin
         pre = 7'd126;
      end else begin
         pre = sum_s[6:0];
      end
      val_mps = (pre > 7'd63);
      // pre-64 keeps the low six bits; 63-pre is their complement when pre <= 63.
      pidx      = val_mps ? pre[5:0] : ~pre[5:0];
      ctx_state = {1'b0, pidx, val_mps};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = 1'b0;
      rd_addr_d = rd_addr_q;
      qc_d      = qc_q;
      v1_d      = rd_q;
      k1_d      = cnt_q;
      we_d      = v1_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;

      if (v1_q) begin
         waddr_d = k1_q;
         wdata_d = ctx_state;
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_RUN;
               rd_d      = 1'b1;
               rd_addr_d = base_in;
               cnt_d     = '0;
               qc_d      = qc_in;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST) begin
               state_d = S_DRAIN;
            end else begin
               rd_d      = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         // Stay until the final context has left stage 1; its write is then on the port.
         S_DRAIN: begin
            if (!v1_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rd_q      <= 1'b0;
         rd_addr_q <= '0;
         qc_q      <= '0;
         v1_q      <= 1'b0;
         k1_q      <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         rd_addr_q <= rd_addr_d;
         qc_q      <= qc_d;
         v1_q      <= v1_d;
         k1_q      <= k1_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.init_rd   = rd_q;
   assign bus.init_addr = rd_addr_q;
   assign bus.ctx_we    = we_q;
   assign bus.ctx_en    = we_q;
   assign bus.ctx_addr  = waddr_q;
   assign bus.ctx_wdata = wdata_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_qdec_ctx_init.sv
// Directed-plus-random bench for qdec_ctx_init: ROM model, context memory model and a
// formula-level reference for every write of every pass.
module tb_qdec_ctx_init;
   localparam int NUM_CTX = 64;
   localparam int CTX_AW  = 6;
   localparam int INIT_AW = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rom     [0:(1<<INIT_AW)-1];
   logic [7:0] ctx_mem [0:NUM_CTX-1];
   logic [7:0] exp_q[$];

   qdec_ctx_init_if #(.CTX_AW(CTX_AW), .INIT_AW(INIT_AW)) bus ();

   qdec_ctx_init #(.NUM_CTX(NUM_CTX), .CTX_AW(CTX_AW), .INIT_AW(INIT_AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state_dbg)
   );

   // ---------------- clock / reset / memories ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      if (bus.init_rd) bus.init_value <= rom[bus.init_addr];
   end

   always @(posedge clk) begin
      if (bus.ctx_en && bus.ctx_we) ctx_mem[bus.ctx_addr] <= bus.ctx_wdata;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_wdata(input int qp, input int iv);
      int qc, m, n, t, sh, pre, ps;
      bit mps;
      qc = (qp < 0) ? 0 : (qp > 51) ? 51 : qp;
      m  = (iv / 16) * 5 - 45;
      n  = (iv % 16) * 8 - 16;
      t  = m * qc;
      sh = (t >= 0) ? (t / 16) : -((-t + 15) / 16);
      pre = sh + n;
      if (pre < 1)   pre = 1;
      if (pre > 126) pre = 126;
      mps = (pre > 63);
      ps  = mps ? pre - 64 : 63 - pre;
      return 8'(ps * 2 + int'(mps));
   endfunction

   function automatic int base_of(input int typ);
      return (typ == 0) ? 0 : (typ == 1) ? NUM_CTX : 2 * NUM_CTX;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},   32'(bus.busy),    32'd0);
      check({tag, "_done"},   32'(bus.done),    32'd0);
      check({tag, "_we"},     32'(bus.ctx_we),  32'd0);
      check({tag, "_en"},     32'(bus.ctx_en),  32'd0);
      check({tag, "_rd"},     32'(bus.init_rd), 32'd0);
   endtask

   // ---------------- driver: one full pass, checked cycle by cycle ----------------
   task automatic run_pass(input int qp, input int typ, input bit noisy);
      int base, writes;
      base   = base_of(typ > 2 ? 2 : typ);
      writes = 0;
      exp_q.delete();
      for (int k = 0; k < NUM_CTX; k++) exp_q.push_back(ref_wdata(qp, int'(rom[base + k])));

      @(negedge clk);
      bus.start     = 1'b1;
      bus.slice_qp  = 7'(qp);
      bus.init_type = 2'(typ);
      for (int c = 1; c <= NUM_CTX + 3; c++) begin
         @(negedge clk);
         check("busy", 32'(bus.busy), 32'((c <= NUM_CTX + 2) ? 1 : 0));
         check("done", 32'(bus.done), 32'((c == NUM_CTX + 3) ? 1 : 0));
         check("init_rd", 32'(bus.init_rd), 32'((c <= NUM_CTX) ? 1 : 0));
         if (c <= NUM_CTX) check("init_addr", 32'(bus.init_addr), 32'(base + c - 1));
         check("ctx_we", 32'(bus.ctx_we), 32'((c >= 3 && c <= NUM_CTX + 2) ? 1 : 0));
         check("ctx_en", 32'(bus.ctx_en), 32'(bus.ctx_we));
         if (bus.ctx_we === 1'b1) begin
            writes++;
            check("ctx_addr", 32'(bus.ctx_addr), 32'(c - 3));
            if (exp_q.size() > 0) check("ctx_wdata", 32'(bus.ctx_wdata), 32'(exp_q.pop_front()));
         end
         // Spurious requests while busy and on the done cycle, with scrambled inputs.
         bus.start     = noisy ? ((c == NUM_CTX + 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
         bus.slice_qp  = 7'($urandom);
         bus.init_type = 2'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      check("write_count", 32'(writes), 32'(NUM_CTX));
      check("post_state", 32'(state_dbg), 32'd0);
      check_idle("post");
   endtask

   task automatic fill_rom_random();
      for (int i = 0; i < (1 << INIT_AW); i++) rom[i] = 8'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int qps[5];
      logic [7:0] snap [0:NUM_CTX-1];
      qps = '{0, 1, 25, 26, 51};
      bus.start = 1'b0;
      bus.slice_qp = '0;
      bus.init_type = '0;
      bus.init_value = '0;
      fill_rom_random();

      // Reset, then 20 idle cycles.
      repeat (3) @(negedge clk);
      check("rst_init_addr", 32'(bus.init_addr), 32'd0);
      check("rst_ctx_addr",  32'(bus.ctx_addr),  32'd0);
      check("rst_ctx_wdata", 32'(bus.ctx_wdata), 32'd0);
      check("rst_state",     32'(state_dbg),     32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("idle");
      end

      // Directed initValues at qp=26.
      rom[0] = 8'd154; rom[1] = 8'd139; rom[2] = 8'd0; rom[3] = 8'd255;
      run_pass(26, 0, 1'b0);
      check("dir_qp26_154", 32'(ctx_mem[0]), 32'h01);
      check("dir_qp26_139", 32'(ctx_mem[1]), 32'h00);
      check("dir_qp26_0",   32'(ctx_mem[2]), 32'h7C);
      check("dir_qp26_255", 32'(ctx_mem[3]), 32'h7D);

      // Clip extremes of pre.
      run_pass(51, 0, 1'b0);
      check("dir_qp51_0", 32'(ctx_mem[2]), 32'h7C);
      run_pass(0, 0, 1'b0);
      check("dir_qp0_255", 32'(ctx_mem[3]), 32'h51);

      // slice_qp clipping: negative behaves as 0, above 51 behaves as 51.
      for (int k = 0; k < NUM_CTX; k++) snap[k] = ctx_mem[k];
      run_pass(-5, 0, 1'b0);
      for (int k = 0; k < NUM_CTX; k++) check("qp_neg_eq_0", 32'(ctx_mem[k]), 32'(snap[k]));
      run_pass(51, 1, 1'b0);
      for (int k = 0; k < NUM_CTX; k++) snap[k] = ctx_mem[k];
      run_pass(63, 1, 1'b0);
      for (int k = 0; k < NUM_CTX; k++) check("qp_63_eq_51", 32'(ctx_mem[k]), 32'(snap[k]));

      // init_type 1, 2 and 3 with request noise during the pass.
      run_pass(30, 1, 1'b1);
      run_pass(40, 2, 1'b1);
      run_pass(12, 3, 1'b1);

      // Reset in the middle of a pass.
      @(negedge clk);
      bus.start = 1'b1; bus.slice_qp = 7'd30; bus.init_type = 2'd0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("abort");
      check("abort_state",     32'(state_dbg),     32'd0);
      check("abort_init_addr", 32'(bus.init_addr), 32'd0);
      check("abort_ctx_addr",  32'(bus.ctx_addr),  32'd0);
      check("abort_ctx_wdata", 32'(bus.ctx_wdata), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < NUM_CTX + 6; i++) begin
         @(negedge clk);
         check_idle("after_abort");
      end
      run_pass(30, 0, 1'b0);

      // Every initValue against every listed qp, initType chosen at random.
      for (int q = 0; q < 5; q++) begin
         for (int chunk = 0; chunk < 4; chunk++) begin
            int typ;
            typ = $urandom_range(0, 3);
            for (int k = 0; k < NUM_CTX; k++) rom[base_of(typ > 2 ? 2 : typ) + k] = 8'(chunk * NUM_CTX + k);
            run_pass(qps[q], typ, 1'($urandom_range(0, 1)));
         end
      end

      // Random slice_qp over the full signed range with random ROM contents.
      for (int i = 0; i < 4; i++) begin
         fill_rom_random();
         run_pass($urandom_range(0, 127) - 64, $urandom_range(0, 3), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
